// File: rtl/tsc_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the TSC datapath.
// Issues one-cycle write strobes, honours stalls, counts retirements and halts at LAST_PC.
module tsc_multicycle_ctrl #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned PC_SIZE   = 8,
  parameter int unsigned LAST_PC   = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_enable,
  input  logic                 wwd_enable,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic [PC_SIZE-1:0]   pc,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic                 out_write,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StWb     = 3'd3,
    StHalt   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

  logic [3:0] opcode;
  logic [5:0] func;
  logic       is_add, is_wwd, is_adi, is_lhi, is_jmp, is_alu;
  logic       at_last, retire, in_fetch;
  logic       unused_ir;

  assign opcode    = ir_q[15:12];
  assign func      = ir_q[5:0];
  assign unused_ir = ^ir_q[11:6];

  assign is_add  = (opcode == 4'd15) && (func == 6'd0);
  assign is_wwd  = (opcode == 4'd15) && (func == 6'd28);
  assign is_adi  = (opcode == 4'd4);
  assign is_lhi  = (opcode == 4'd6);
  assign is_jmp  = (opcode == 4'd9);
  assign is_alu  = is_add || is_adi || is_lhi;
  assign at_last = (pc == PC_SIZE'(LAST_PC));

  // Selects follow the latched IR in every state except FETCH, where the copy is stale.
  assign in_fetch = (state_q == StFetch);
  assign pc_src   = !in_fetch && is_jmp;
  assign reg_dst  = !in_fetch && is_add;
  assign alu_src  = !in_fetch && (is_adi || is_lhi);
  always_comb begin
    alu_op = 2'b00;
    if (!in_fetch) begin
      if (is_lhi)      alu_op = 2'b01;
      else if (is_wwd) alu_op = 2'b10;
    end
  end

  assign state    = reset ? 3'd0 : state_q;
  assign halted   = (state_q == StHalt);
  assign num_inst = num_inst_q;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    num_inst_d = num_inst_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    out_write  = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      StFetch: begin
        ir_write = 1'b1;
        ir_d     = instr;
        state_d  = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (is_alu) begin
          state_d = StWb;
        end else if (is_jmp) begin
          retire = 1'b1;
        end else if (is_wwd) begin
          out_write = wwd_enable;
          retire    = 1'b1;
        end else begin
          illegal = 1'b1;
          retire  = 1'b1;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    if (retire) begin
      num_inst_d = num_inst_q + 1'b1;
      if (at_last && !is_jmp) begin
        state_d = StHalt;
      end else begin
        pc_write = 1'b1;
        state_d  = StFetch;
      end
    end

    // A stall or pending reset suppresses every strobe and freezes all state.
    if (!cpu_enable || reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      out_write  = 1'b0;
      illegal    = 1'b0;
      state_d    = state_q;
      ir_d       = ir_q;
      num_inst_d = num_inst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      ir_q       <= '0;
      num_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      num_inst_q <= num_inst_d;
    end
  end

endmodule
